// File: rtl/inst_encoder.sv
// ---------------------------------------------------------------------------
// inst_encoder
//
// Streaming instruction encoder, the inverse of the immediate extender.
// Each input carries decoded fields, a 32-bit immediate and an ExtSel mode.
// If the extender can reproduce the immediate from the packed word, the word
// is emitted with an auto-incrementing byte address. Otherwise the input is
// dropped and counted.
//
// Ports
//   CLK, RST_n        clock (rising edge), asynchronous active-low reset
//   load_base         one-cycle pulse: next_addr <= base_addr
//   base_addr         start address for subsequent words
//   in_valid/in_ready input handshake (in_ready = !out_valid || out_ready)
//   Op,Rs,Rt,Rd,Funct instruction fields
//   ExtSel            00 shamt, 01 zero-ext, 10 sign-ext, 11 none
//   imm_32            desired extended immediate
//   out_valid/out_ready output handshake
//   out_inst,out_addr packed word and its byte address
//   err_pulse         one cycle after a rejected accept
//   err_cnt           saturating count of rejected inputs
// ---------------------------------------------------------------------------
module inst_encoder #(
    parameter int ADDR_W = 32,
    parameter int ERR_W  = 8
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              load_base,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        Op,
    input  logic [4:0]        Rs,
    input  logic [4:0]        Rt,
    input  logic [4:0]        Rd,
    input  logic [5:0]        Funct,
    input  logic [1:0]        ExtSel,
    input  logic [31:0]       imm_32,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_cnt
);

    logic              fit;
    logic [31:0]       packed_w;
    logic              accept;
    logic [ADDR_W-1:0] cur_addr;

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_inst_q,  out_inst_d;
    logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic              err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]  err_cnt_q,   err_cnt_d;

    // Representability check and packing per immediate mode.
    always_comb begin
        fit      = 1'b0;
        packed_w = '0;
        case (ExtSel)
            2'b00: begin
                fit      = (imm_32[31:5] == '0);
                packed_w = {Op, 5'b0, Rt, Rd, imm_32[4:0], Funct};
            end
            2'b01: begin
                fit      = (imm_32[31:16] == '0);
                packed_w = {Op, Rs, Rt, imm_32[15:0]};
            end
            2'b10: begin
                fit      = (imm_32[31:16] == {16{imm_32[15]}});
                packed_w = {Op, Rs, Rt, imm_32[15:0]};
            end
            default: begin
                fit      = (imm_32 == '0);
                packed_w = {Op, Rs, Rt, Rd, 5'b0, Funct};
            end
        endcase
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // A base load in the same cycle as a fit accept addresses that word.
    assign cur_addr = load_base ? base_addr : next_addr_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_addr_d  = out_addr_q;
        next_addr_d = cur_addr;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (fit) begin
                out_valid_d = 1'b1;
                out_inst_d  = packed_w;
                out_addr_d  = cur_addr;
                next_addr_d = cur_addr + ADDR_W'(4);
            end else begin
                err_pulse_d = 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + ERR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_addr_q  <= '0;
            next_addr_q <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_addr_q  <= out_addr_d;
            next_addr_q <= next_addr_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_addr  = out_addr_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// ---------------------------------------------------------------------------
// tb_inst_encoder
//
// Self-checking bench for inst_encoder. A scoreboard queue holds the word
// expected in the output register; fit/pack/extend rules are modelled with
// plain arithmetic. Directed scenarios are followed by a randomized stream.
// ---------------------------------------------------------------------------
module tb_inst_encoder;

    logic        CLK;
    logic        RST_n;
    logic        load_base;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  Op;
    logic [4:0]  Rs, Rt, Rd;
    logic [5:0]  Funct;
    logic [1:0]  ExtSel;
    logic [31:0] imm_32;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        err_pulse;
    logic [7:0]  err_cnt;

    inst_encoder #(.ADDR_W(32), .ERR_W(8)) dut (
        .CLK(CLK), .RST_n(RST_n), .load_base(load_base), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .Op(Op), .Rs(Rs), .Rt(Rt),
        .Rd(Rd), .Funct(Funct), .ExtSel(ExtSel), .imm_32(imm_32),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_addr(out_addr), .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] imm;
        logic [1:0]  sel;
    } ent_t;

    ent_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          rej = 0;
    int          drained = 0;
    logic [31:0] addr_m = '0;
    logic        exp_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit fit_m(input logic [1:0] s, input logic [31:0] v);
        case (s)
            2'd0:    return v < 32;
            2'd1:    return v < 32'h1_0000;
            2'd2:    return ($signed(v) >= -32768) && ($signed(v) <= 32767);
            default: return v == 0;
        endcase
    endfunction

    function automatic logic [31:0] pack_m(input logic [1:0] s, input logic [31:0] v);
        logic [31:0] op, rs, rt, rd, fn;
        op = 32'(Op); rs = 32'(Rs); rt = 32'(Rt); rd = 32'(Rd); fn = 32'(Funct);
        case (s)
            2'd0:    return (op << 26) | (rt << 16) | (rd << 11) | (v << 6) | fn;
            2'd1,
            2'd2:    return (op << 26) | (rs << 21) | (rt << 16) | (v & 32'hFFFF);
            default: return (op << 26) | (rs << 21) | (rt << 16) | (rd << 11) | fn;
        endcase
    endfunction

    // Immediate extender: recovers the immediate from a packed word.
    function automatic logic [31:0] ext_m(input logic [31:0] w, input logic [1:0] s);
        logic [31:0] lo;
        lo = w & 32'hFFFF;
        case (s)
            2'd0:    return (w >> 6) & 32'd31;
            2'd1:    return lo;
            2'd2:    return (lo >= 32768) ? lo - 32'd65536 : lo;
            default: return 32'd0;
        endcase
    endfunction

    // One clock cycle with the inputs currently driven. Called at posedge+1.
    task automatic tick(output bit acc);
        bit          f;
        logic [31:0] cur;
        ent_t        e;
        #1;
        chk("in_ready", in_ready, !out_valid || out_ready);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", out_valid, 1'b0);
            end else begin
                e = q.pop_front();
                chk("roundtrip", ext_m(out_inst, e.sel), e.imm);
                drained++;
            end
        end
        cur = load_base ? base_addr : addr_m;
        f   = fit_m(ExtSel, imm_32);
        if (acc && f) begin
            e.inst = pack_m(ExtSel, imm_32);
            e.addr = cur;
            e.imm  = imm_32;
            e.sel  = ExtSel;
            q.push_back(e);
            cur = cur + 32'd4;
        end
        addr_m  = cur;
        exp_err = acc && !f;
        if (acc && !f) rej++;
        @(posedge CLK);
        #1;
        chk("err_pulse", err_pulse, exp_err);
        chk("err_cnt", err_cnt, (rej > 255) ? 255 : rej);
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("out_inst", out_inst, q[0].inst);
            chk("out_addr", out_addr, q[0].addr);
        end
    endtask

    task automatic idle(input int n);
        bit a;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(a);
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] fn, input logic [1:0] s,
                        input logic [31:0] v);
        bit a;
        a = 1'b0;
        Op = op; Rs = rs; Rt = rt; Rd = rd; Funct = fn; ExtSel = s; imm_32 = v;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !a; i++) tick(a);
        chk("send_accept", a, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        in_valid = 1'b0;
        load_base = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_err_pulse", err_pulse, 1'b0);
        chk("rst_err_cnt", err_cnt, 32'd0);
        q.delete();
        rej = 0;
        addr_m = '0;
        exp_err = 1'b0;
        @(negedge CLK);
        RST_n = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bit a;
        int sent, d0;
        RST_n = 1'b1; load_base = 1'b0; base_addr = '0; in_valid = 1'b0;
        Op = '0; Rs = '0; Rt = '0; Rd = '0; Funct = '0; ExtSel = '0; imm_32 = '0;
        out_ready = 1'b1;
        #3;
        do_reset();

        // Base load, then a sign-extended negative immediate.
        load_base = 1'b1; base_addr = 32'h0000_1000;
        tick(a);
        load_base = 1'b0;
        send(6'h08, 5'd1, 5'd2, 5'd0, 6'd0, 2'b10, 32'hFFFF_FF80);
        chk("dir_inst_sext", out_inst, 32'h2022_FF80);
        chk("dir_addr_base", out_addr, 32'h0000_1000);

        // Zero-ext 0x8000 fits; sign-ext 0x8000 does not.
        send(6'h0D, 5'd3, 5'd4, 5'd0, 6'd0, 2'b01, 32'h0000_8000);
        chk("dir_zext_lo", out_inst & 32'hFFFF, 32'h8000);
        send(6'h08, 5'd3, 5'd4, 5'd0, 6'd0, 2'b10, 32'h0000_8000);
        chk("dir_rej_pulse", err_pulse, 1'b1);
        chk("dir_rej_cnt", err_cnt, 32'd1);
        chk("dir_rej_noout", out_valid, 1'b0);

        // Shift amount: 5 fits, 32 does not. Next word must be at 0x1008.
        send(6'h00, 5'd9, 5'd3, 5'd4, 6'd0, 2'b00, 32'd5);
        chk("dir_shamt", out_inst, 32'h0003_2140);
        chk("dir_addr_after_rej", out_addr, 32'h0000_1008);
        send(6'h00, 5'd0, 5'd3, 5'd4, 6'd0, 2'b00, 32'd32);
        chk("dir_shamt_rej", err_cnt, 32'd2);
        idle(2);

        // Back-to-back stream of 4 words with a 3-cycle output stall.
        sent = 0;
        d0 = drained;
        for (int c = 0; c < 12; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            if (sent < 4) begin
                in_valid = 1'b1;
                Op = 6'($urandom); Rs = 5'($urandom); Rt = 5'($urandom);
                ExtSel = 2'b01; imm_32 = $urandom_range(0, 65535);
            end else begin
                in_valid = 1'b0;
            end
            tick(a);
            if (a) sent++;
        end
        out_ready = 1'b1;
        chk("stall_sent", sent, 4);
        chk("stall_drained", drained - d0, 4);

        // Address wrap.
        load_base = 1'b1; base_addr = 32'hFFFF_FFFC;
        tick(a);
        load_base = 1'b0;
        send(6'h23, 5'd1, 5'd2, 5'd0, 6'd0, 2'b10, 32'd16);
        chk("wrap_addr0", out_addr, 32'hFFFF_FFFC);
        send(6'h23, 5'd1, 5'd2, 5'd0, 6'd0, 2'b10, 32'd20);
        chk("wrap_addr1", out_addr, 32'h0000_0000);

        // Saturate the reject counter.
        in_valid = 1'b1; ExtSel = 2'b11; imm_32 = 32'd1;
        for (int i = 0; i < 300; i++) tick(a);
        in_valid = 1'b0;
        chk("err_sat", err_cnt, 32'd255);
        idle(1);

        // Reset mid-stream while a word is pending.
        out_ready = 1'b0;
        send(6'h0F, 5'd0, 5'd7, 5'd0, 6'd0, 2'b01, 32'h1234);
        chk("pre_rst_valid", out_valid, 1'b1);
        do_reset();
        out_ready = 1'b1;

        // Randomized stream.
        for (int i = 0; i < 2000; i++) begin
            int k;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            load_base = ($urandom_range(0, 49) == 0);
            base_addr = $urandom & 32'hFFFF_FFFC;
            Op = 6'($urandom); Rs = 5'($urandom); Rt = 5'($urandom);
            Rd = 5'($urandom); Funct = 6'($urandom); ExtSel = 2'($urandom);
            k = $urandom_range(0, 4);
            case (k)
                0:       imm_32 = $urandom;
                1:       imm_32 = $urandom_range(0, 31);
                2:       imm_32 = $urandom_range(0, 65535);
                3:       imm_32 = ($urandom_range(0, 1) != 0) ? (32'hFFFF_0000 | 32'($urandom_range(32768, 65535)))
                                                             : 32'($urandom_range(0, 32767));
                default: imm_32 = 32'd0;
            endcase
            tick(a);
        end
        load_base = 1'b0;
        out_ready = 1'b1;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
